// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states and decode helpers.
// Imported by the unit, its align datapath and the testbench.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP,
    FAULT
  } lsu_state_e;

  // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
  function automatic logic f3_illegal(input logic store, input logic [2:0] funct3);
    if (store) return funct3[2] | (funct3[1:0] == 2'b11);
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and data-memory bus of the load/store unit.
// slave = the LSU's view; master = the core + memory side driving it.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_fault;
  logic              busy;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, busy,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, busy,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte/halfword datapath: load extract + sign/zero extension and SB/SH merge.
// Low address bits beyond natural alignment are ignored, so unaligned H/W ops snap down.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    byte_sel   = word[8*addr_lo +: 8];
    half_sel   = addr_lo[1] ? word[31:16] : word[15:0];
    load_data  = word;
    merge_data = wdata;

    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      default: load_data = word;
    endcase

    case (funct3[1:0])
      2'b00: begin
        merge_data = word;
        merge_data[8*addr_lo +: 8] = wdata[7:0];
      end
      2'b01: merge_data = addr_lo[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store sequencer in front of a word-only data memory (RMW for SB/SH).
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/W ops instead of aligning them down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        funct3_q;
  logic              store_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] merge_q;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;
  logic [ADDR_W-1:0] word_addr;
  logic              handshake;

  logic              req_ready;
  logic              resp_valid;
  logic              resp_fault;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign handshake = bus.req_valid & req_ready;

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .word       (bus.mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      rdata_q  <= '0;
      merge_q  <= '0;
    end else begin
      if (handshake) begin
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        funct3_q <= bus.req_funct3;
        store_q  <= bus.req_store;
      end
      // Memory data is only valid during ACCESS, so both results are captured there.
      if (state_q == ACCESS) begin
        rdata_q <= store_q ? '0 : load_data;
        merge_q <= merge_data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_fault = 1'b0;
    resp_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          if (f3_illegal(bus.req_store, bus.req_funct3))
            state_d = FAULT;
          else if (TRAP_EN && misaligned(bus.req_funct3, bus.req_addr[1:0]))
            state_d = FAULT;
          else
            state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_read = 1'b1;
        mem_addr = word_addr;
        if (store_q && funct3_q[1:0] == F3_W[1:0]) begin
          mem_write = 1'b1;
          mem_wdata = wdata_q;
          state_d   = RESP;
        end else if (store_q) begin
          state_d = WRITE;
        end else begin
          state_d = RESP;
        end
      end
      WRITE: begin
        mem_write = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = merge_q;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        state_d    = IDLE;
      end
      FAULT: begin
        resp_valid = 1'b1;
        resp_fault = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = req_ready;
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_valid = resp_valid;
  assign bus.resp_fault = resp_fault;
  assign bus.resp_rdata = resp_rdata;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

endmodule
